// File: rtl/frost_boot_pkg.sv
// frost_boot_pkg: shared state encodings and sizing constants for the UART boot loader
package frost_boot_pkg;
  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_LEN_W      = 16;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_LO = 3'd1;
  localparam state_t S_LEN_HI = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_CHECK  = 3'd5;
  localparam state_t S_DONE   = 3'd6;
  localparam state_t S_ERROR  = 3'd7;
endpackage

// File: rtl/boot_byte_fetch.sv
// boot_byte_fetch: pops one byte from the UART FIFO, then forces a gap cycle so rx_empty can settle
module boot_byte_fetch (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  logic       rd_q, rd_d;
  logic [7:0] byte_q;
  assign rd_d       = en & ~rx_empty & ~rd_q;
  assign rd_uart    = rd_q;
  assign byte_valid = rd_q;
  assign byte_data  = byte_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q   <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      rd_q <= rd_d;
      if (rd_d) byte_q <= r_data;
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a length-prefixed little-endian word image from the UART into program RAM.
// Define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_boot_loader
  import frost_boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_en,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam state_t FIN = S_CHECK;
`else
  localparam state_t FIN = S_DONE;
`endif
  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       data_q, data_d;
  logic              fetch_en, byte_valid;
  logic [7:0]        byte_data;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  assign fetch_en  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign mem_we    = state_q == S_WRITE;
  assign mem_addr  = word_q;
  assign mem_wdata = data_q;
  assign done      = state_q == S_DONE;
  assign err       = state_q == S_ERROR;
  assign cpu_reset = state_q != S_DONE;
  boot_byte_fetch u_fetch (
    .clk       (clk),
    .reset     (reset),
    .en        (fetch_en),
    .rx_empty  (rx_empty),
    .r_data    (r_data),
    .rd_uart   (rd_uart),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bidx_d  = bidx_q;
    data_d  = data_q;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    csum_d  = csum_q ^ ((byte_valid && state_q != S_CHECK) ? byte_data : 8'h00);
`endif
    case (state_q)
      S_IDLE:   state_d = boot_en ? S_LEN_LO : S_DONE;
      S_LEN_LO: if (byte_valid) begin
        len_d   = LEN_W'(byte_data);
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (byte_valid) begin
        len_d   = LEN_W'({byte_data, len_q[7:0]});
        state_d = len_d == '0 ? FIN : 32'(len_d) > MAX_WORDS ? S_ERROR : S_DATA;
      end
      S_DATA: if (byte_valid) begin
        data_d[8*bidx_q +: 8] = byte_data;
        bidx_d  = bidx_q + 2'd1;
        state_d = 32'(bidx_q) == BYTES_PER_WORD - 1 ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        state_d = 32'(word_q) == 32'(len_q) - 32'd1 ? FIN : S_DATA;
        word_d  = state_d == S_DATA ? word_q + ADDR_W'(1) : word_q;
      end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      S_CHECK: if (byte_valid) state_d = byte_data == csum_q ? S_DONE : S_ERROR;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      data_q  <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      data_q  <= data_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed checks of header parsing, word assembly, pop pacing and reset recovery
module tb_uart_boot_loader;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic        clk = 1'b0, reset = 1'b0, boot_en = 1'b0, rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart, mem_we, cpu_reset, done, err;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  fifo[$];
  logic [63:0] wr_q[$];
  logic [7:0]  cs;
  int          n_assert = 0, n_fail = 0, rd_cnt = 0, gap = 0, gap_max = 0;
  logic        prev_rd = 1'b0;
  uart_boot_loader dut (
    .clk(clk), .reset(reset), .boot_en(boot_en), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rd_uart) begin
      check("rd_gap", {63'd0, prev_rd}, 64'd0);
      check("rd_nonempty", {63'd0, rx_empty}, 64'd0);
      rd_cnt++;
      if (fifo.size() != 0) void'(fifo.pop_front());
      gap = $urandom_range(0, gap_max);
    end
    prev_rd = rd_uart;
    if (mem_we) wr_q.push_back({32'(mem_addr), mem_wdata});
    if (gap > 0) gap--;
    rx_empty = fifo.size() == 0 || gap > 0;
    r_data   = fifo.size() != 0 ? fifo[0] : 8'h00;
  end
  task automatic push_b(input logic [7:0] b);
    fifo.push_back(b);
    cs = cs ^ b;
  endtask
  task automatic end_frame();
    if (CS != 0) fifo.push_back(cs);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rd"}, {63'd0, rd_uart}, 64'd0);
    check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask
  task automatic start(input logic boot, input int gmax);
    reset = 1'b0;
    fifo.delete();
    wr_q.delete();
    rd_cnt = 0;
    cs = 8'h00;
    gap_max = gmax;
    boot_en = boot;
    repeat (2) @(negedge clk);
    check_reset("reset");
  endtask
  task automatic wait_end(input string tag);
    for (int i = 0; i < 40000 && !(done || err); i++) @(negedge clk);
    check({tag, "_timeout"}, {63'd0, done | err}, 64'd1);
  endtask
  task automatic frame_8(input int gmax);
    start(1'b1, gmax);
    push_b(8'h02); push_b(8'h00);
    for (int i = 1; i <= 8; i++) push_b(8'(i * 17));
    end_frame();
    reset = 1'b1;
    wait_end("f8");
    check("f8_done", {62'd0, done, err}, 64'd2);
    check("f8_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    check("f8_nwr", 64'(wr_q.size()), 64'd2);
    check("f8_w0", wr_q[0], {32'd0, 32'h44332211});
    check("f8_w1", wr_q[1], {32'd1, 32'h88776655});
    check("f8_nrd", 64'(rd_cnt), 64'(10 + CS));
  endtask
  initial begin
    start(1'b0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("skip_done", {63'd0, done}, 64'd1);
    check("skip_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    check("skip_nrd", 64'(rd_cnt), 64'd0);
    frame_8(0);
    fifo.push_back(8'h99);
    repeat (10) @(negedge clk);
    check("post_done_nrd", 64'(rd_cnt), 64'(10 + CS));
    check("post_done_nwr", 64'(wr_q.size()), 64'd2);
    frame_8(20);
    start(1'b1, 0);
    push_b(8'h00); push_b(8'h08);
    for (int i = 0; i < 8192; i++) push_b(8'(i));
    end_frame();
    reset = 1'b1;
    wait_end("max");
    check("max_done", {62'd0, done, err}, 64'd2);
    check("max_nwr", 64'(wr_q.size()), 64'd2048);
    for (int w = 0; w < wr_q.size(); w++)
      check("max_word", wr_q[w], {32'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    check("max_last_addr", 64'(wr_q[2047][63:32]), 64'h7FF);
    start(1'b1, 0);
    push_b(8'h01); push_b(8'h08);
    for (int i = 0; i < 8; i++) push_b(8'(i));
    reset = 1'b1;
    wait_end("over");
    repeat (4) @(negedge clk);
    check("over_err", {62'd0, done, err}, 64'd1);
    check("over_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("over_nwr", 64'(wr_q.size()), 64'd0);
    check("over_nrd", 64'(rd_cnt), 64'd2);
    start(1'b1, 0);
    push_b(8'h02); push_b(8'h00);
    for (int i = 1; i <= 8; i++) push_b(8'(i));
    reset = 1'b1;
    for (int i = 0; i < 200 && rd_cnt < 7; i++) @(negedge clk);
    check("mid_reached", 64'(rd_cnt), 64'd7);
    #2 reset = 1'b0;
    #1 check_reset("mid");
    start(1'b1, 0);
    push_b(8'h01); push_b(8'h00);
    push_b(8'hA1); push_b(8'hB2); push_b(8'hC3); push_b(8'hD4);
    end_frame();
    reset = 1'b1;
    wait_end("restart");
    check("restart_done", {62'd0, done, err}, 64'd2);
    check("restart_nwr", 64'(wr_q.size()), 64'd1);
    check("restart_w0", wr_q[0], {32'd0, 32'hD4C3B2A1});
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      start(1'b1, 0);
      fifo = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      fifo.push_back(k == 0 ? 8'h01 : 8'h00);
      reset = 1'b1;
      wait_end("csum");
      check("csum_result", {62'd0, done, err}, k == 0 ? 64'd2 : 64'd1);
      check("csum_w0", wr_q[0], {32'd0, 32'hDDCCBBAA});
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
